// File: rtl/tt_microtile_pkg.sv
// -----------------------------------------------------------------------------
// tt_microtile_pkg
// Shared constants for the microtile result sink: data/FIFO sizing, the
// illegal sum code, the ui_in bit map and the uo_out field map for both views.
// It also holds the two view packing helpers used by the top level.
// -----------------------------------------------------------------------------
package tt_microtile_pkg;

    // Result width, FIFO depth (power of two) and occupancy counter width
    localparam int DW    = 5;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int AW    = $clog2(DEPTH);

    // A 5-bit nibble sum tops out at 30, so the all-ones code is never valid
    localparam logic [DW-1:0] ILLEGAL_SUM = 5'd31;

    // Occupancy value that means "full"
    localparam logic [CW-1:0] COUNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] COUNT_EMPTY = {CW{1'b0}};

    // ui_in bit map
    localparam int DATA_LSB = 0;
    localparam int DATA_MSB = 4;
    localparam int PUSH_BIT = 5;
    localparam int POP_BIT  = 6;
    localparam int VIEW_BIT = 7;

    // uo_out field map, data view: {full, empty, err, head}
    localparam int DV_FULL_BIT  = 7;
    localparam int DV_EMPTY_BIT = 6;
    localparam int DV_ERR_BIT   = 5;
    localparam int DV_HEAD_LSB  = 0;

    // uo_out field map, status view: {ovf, unf, err, 2'b00, count}
    localparam int SV_OVF_BIT   = 7;
    localparam int SV_UNF_BIT   = 6;
    localparam int SV_ERR_BIT   = 5;
    localparam int SV_COUNT_LSB = 0;

    typedef enum logic {
        VIEW_DATA   = 1'b0,
        VIEW_STATUS = 1'b1
    } view_e;

    // Pack the data view byte
    function automatic logic [7:0] pack_data_view(input logic          full,
                                                  input logic          empty,
                                                  input logic          err,
                                                  input logic [DW-1:0] head);
        logic [7:0] v;
        v                              = 8'h00;
        v[DV_FULL_BIT]                 = full;
        v[DV_EMPTY_BIT]                = empty;
        v[DV_ERR_BIT]                  = err;
        v[DV_HEAD_LSB +: DW]           = head;
        return v;
    endfunction

    // Pack the status view byte; bits [4:3] stay zero
    function automatic logic [7:0] pack_status_view(input logic          ovf,
                                                    input logic          unf,
                                                    input logic          err,
                                                    input logic [CW-1:0] count);
        logic [7:0] v;
        v                              = 8'h00;
        v[SV_OVF_BIT]                  = ovf;
        v[SV_UNF_BIT]                  = unf;
        v[SV_ERR_BIT]                  = err;
        v[SV_COUNT_LSB +: CW]          = count;
        return v;
    endfunction

endpackage

// File: rtl/tt_microtile_edge.sv
// -----------------------------------------------------------------------------
// tt_microtile_edge
// Rising-edge detector for a level strobe. The previous level is registered
// every cycle; o_evt is high in the cycle where the level is 1 and the
// registered copy is still 0, so a held strobe yields exactly one event.
// Reset clears the history, so a level held high through reset release
// produces one event on the first edge after release.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   i_lvl    raw level strobe
//   o_evt    one-cycle rising-edge event (valid for the upcoming edge)
// -----------------------------------------------------------------------------
module tt_microtile_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_lvl,
    output logic o_evt
);

    logic r_q;

    // Register the raw level for comparison on the next cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= 1'b0;
        end else begin
            r_q <= i_lvl;
        end
    end

    assign o_evt = i_lvl & ~r_q;

endmodule

// File: rtl/tt_microtile_sink.sv
// -----------------------------------------------------------------------------
// tt_microtile_sink
// Receives 5-bit nibble-sum results from an upstream adder tile, buffers them
// in a DEPTH-entry FIFO and lets the host pop them and read them back.
// Overflow (push while full, no pop), underflow (pop while empty) and illegal
// value (push of 31) are flagged with sticky bits cleared only by rst_n.
// Ports:
//   clk     tile clock, rising edge
//   rst_n   asynchronous active-low reset
//   ui_in   [4:0] result data, [5] push strobe, [6] pop strobe,
//           [7] view select (0 = data, 1 = status)
//   uo_out  data view   {full, empty, err, head[4:0]}
//           status view {ovf, unf, err, 2'b00, count[2:0]}
// -----------------------------------------------------------------------------
module tt_microtile_sink
    import tt_microtile_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          r_unf;
    logic          r_err;

    logic          w_push_evt;
    logic          w_pop_evt;
    logic [DW-1:0] w_data;
    logic          w_full;
    logic          w_empty;
    logic          w_legal;
    logic          w_pop_acc;
    logic          w_push_acc;
    logic          w_set_ovf;
    logic          w_set_unf;
    logic          w_set_err;
    logic [DW-1:0] w_head;

    tt_microtile_edge u_push_edge (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_lvl   (ui_in[PUSH_BIT]),
        .o_evt   (w_push_evt)
    );

    tt_microtile_edge u_pop_edge (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_lvl   (ui_in[POP_BIT]),
        .o_evt   (w_pop_evt)
    );

    assign w_data  = ui_in[DATA_MSB:DATA_LSB];
    assign w_full  = (r_count == COUNT_FULL);
    assign w_empty = (r_count == COUNT_EMPTY);
    assign w_legal = (w_data != ILLEGAL_SUM);

    // Accept/flag decisions, all from pre-edge occupancy. A pop frees a slot
    // in the same edge, so a full FIFO still takes a push when a pop accompanies it.
    always_comb begin
        w_pop_acc  = 1'b0;
        w_push_acc = 1'b0;
        w_set_ovf  = 1'b0;
        w_set_unf  = 1'b0;
        w_set_err  = 1'b0;
        if (w_pop_evt) begin
            w_pop_acc = ~w_empty;
            w_set_unf = w_empty;
        end else begin
            w_pop_acc = 1'b0;
            w_set_unf = 1'b0;
        end
        if (w_push_evt && !w_legal) begin
            w_set_err = 1'b1;
        end else if (w_push_evt) begin
            w_push_acc = ~w_full | w_pop_acc;
            w_set_ovf  = w_full & ~w_pop_acc;
        end else begin
            w_push_acc = 1'b0;
            w_set_ovf  = 1'b0;
            w_set_err  = 1'b0;
        end
    end

    // FIFO storage, pointers, occupancy and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {DW{1'b0}};
            end
            r_wp    <= {AW{1'b0}};
            r_rp    <= {AW{1'b0}};
            r_count <= {CW{1'b0}};
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_push_acc) begin
                r_mem[r_wp] <= w_data;
                r_wp        <= r_wp + AW'(1);
            end
            if (w_pop_acc) begin
                r_rp <= r_rp + AW'(1);
            end
            case ({w_push_acc, w_pop_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_ovf <= r_ovf | w_set_ovf;
            r_unf <= r_unf | w_set_unf;
            r_err <= r_err | w_set_err;
        end
    end

    // Empty FIFO shows zero on head rather than whatever the slot last held
    always_comb begin
        if (w_empty) begin
            w_head = {DW{1'b0}};
        end else begin
            w_head = r_mem[r_rp];
        end
    end

    // View mux over registered state; switching views never touches state
    always_comb begin
        if (view_e'(ui_in[VIEW_BIT]) == VIEW_STATUS) begin
            uo_out = pack_status_view(r_ovf, r_unf, r_err, r_count);
        end else begin
            uo_out = pack_data_view(w_full, w_empty, r_err, w_head);
        end
    end

endmodule

// File: tb/tb_tt_microtile_sink.sv
// -----------------------------------------------------------------------------
// tb_tt_microtile_sink
// Directed vectors for the microtile result sink. Each record gives the ui_in
// value driven before one rising edge (optionally preceded by a reset) and the
// expected uo_out in both views after that edge. The reset-mid-stream case is
// a hand-written sequence.
// -----------------------------------------------------------------------------
module tb_tt_microtile_sink;

    logic       clk;
    logic       rst_n;
    logic [7:0] ui_in;
    logic [7:0] uo_out;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic       rst;
        logic [7:0] ui;
        logic [7:0] exp_d;
        logic [7:0] exp_s;
    } vec_t;

    vec_t vecs[$];

    tt_microtile_sink dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ui_in  (ui_in),
        .uo_out (uo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic rst, input logic [7:0] ui,
                       input logic [7:0] ed, input logic [7:0] es);
        vec_t v;
        v.rst   = rst;
        v.ui    = ui;
        v.exp_d = ed;
        v.exp_s = es;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", nm, got, exp);
        end
    endtask

    // Read both views between edges; only the view bit changes
    task automatic check_views(input string nm, input logic [7:0] ed, input logic [7:0] es);
        ui_in[7] = 1'b0;
        #1;
        check({nm, "_data"}, uo_out, ed);
        ui_in[7] = 1'b1;
        #1;
        check({nm, "_stat"}, uo_out, es);
        ui_in[7] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ui_in = 8'h00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        ui_in = 8'h00;

        // Push 5, 17, 30, each held 3 cycles, then pop all
        add(1'b0, 8'h25, 8'h05, 8'h01);
        add(1'b0, 8'h25, 8'h05, 8'h01);
        add(1'b0, 8'h25, 8'h05, 8'h01);
        add(1'b0, 8'h00, 8'h05, 8'h01);
        add(1'b0, 8'h31, 8'h05, 8'h02);
        add(1'b0, 8'h31, 8'h05, 8'h02);
        add(1'b0, 8'h31, 8'h05, 8'h02);
        add(1'b0, 8'h00, 8'h05, 8'h02);
        add(1'b0, 8'h3E, 8'h05, 8'h03);
        add(1'b0, 8'h3E, 8'h05, 8'h03);
        add(1'b0, 8'h3E, 8'h05, 8'h03);
        add(1'b0, 8'h00, 8'h05, 8'h03);
        add(1'b0, 8'h40, 8'h11, 8'h02);
        add(1'b0, 8'h40, 8'h11, 8'h02);
        add(1'b0, 8'h00, 8'h11, 8'h02);
        add(1'b0, 8'h40, 8'h1E, 8'h01);
        add(1'b0, 8'h00, 8'h1E, 8'h01);
        add(1'b0, 8'h40, 8'h40, 8'h00);
        add(1'b0, 8'h00, 8'h40, 8'h00);
        // Fill with 1..4, overflow with 9, drain
        add(1'b0, 8'h21, 8'h01, 8'h01);
        add(1'b0, 8'h00, 8'h01, 8'h01);
        add(1'b0, 8'h22, 8'h01, 8'h02);
        add(1'b0, 8'h00, 8'h01, 8'h02);
        add(1'b0, 8'h23, 8'h01, 8'h03);
        add(1'b0, 8'h00, 8'h01, 8'h03);
        add(1'b0, 8'h24, 8'h81, 8'h04);
        add(1'b0, 8'h00, 8'h81, 8'h04);
        add(1'b0, 8'h29, 8'h81, 8'h84);
        add(1'b0, 8'h00, 8'h81, 8'h84);
        add(1'b0, 8'h40, 8'h02, 8'h83);
        add(1'b0, 8'h00, 8'h02, 8'h83);
        add(1'b0, 8'h40, 8'h03, 8'h82);
        add(1'b0, 8'h00, 8'h03, 8'h82);
        add(1'b0, 8'h40, 8'h04, 8'h81);
        add(1'b0, 8'h00, 8'h04, 8'h81);
        add(1'b0, 8'h40, 8'h40, 8'h80);
        add(1'b0, 8'h00, 8'h40, 8'h80);
        // Fresh: fill 1..4, then push 7 with pop on the same edge, drain
        add(1'b1, 8'h21, 8'h01, 8'h01);
        add(1'b0, 8'h00, 8'h01, 8'h01);
        add(1'b0, 8'h22, 8'h01, 8'h02);
        add(1'b0, 8'h00, 8'h01, 8'h02);
        add(1'b0, 8'h23, 8'h01, 8'h03);
        add(1'b0, 8'h00, 8'h01, 8'h03);
        add(1'b0, 8'h24, 8'h81, 8'h04);
        add(1'b0, 8'h00, 8'h81, 8'h04);
        add(1'b0, 8'h67, 8'h82, 8'h04);
        add(1'b0, 8'h00, 8'h82, 8'h04);
        add(1'b0, 8'h40, 8'h03, 8'h03);
        add(1'b0, 8'h00, 8'h03, 8'h03);
        add(1'b0, 8'h40, 8'h04, 8'h02);
        add(1'b0, 8'h00, 8'h04, 8'h02);
        add(1'b0, 8'h40, 8'h07, 8'h01);
        add(1'b0, 8'h00, 8'h07, 8'h01);
        add(1'b0, 8'h40, 8'h40, 8'h00);
        add(1'b0, 8'h00, 8'h40, 8'h00);
        // Fresh: underflow, illegal 31, then push 12 with pop while empty
        add(1'b1, 8'h40, 8'h40, 8'h40);
        add(1'b0, 8'h00, 8'h40, 8'h40);
        add(1'b0, 8'h3F, 8'h60, 8'h60);
        add(1'b0, 8'h00, 8'h60, 8'h60);
        add(1'b0, 8'h6C, 8'h2C, 8'h61);
        add(1'b0, 8'h00, 8'h2C, 8'h61);

        // Reset state while rst_n is held low, then idle with view toggling
        #3;
        check_views("in_reset", 8'h40, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_views($sformatf("idle%0d", i), 8'h40, 8'h00);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) begin
                do_reset();
            end
            ui_in = vecs[i].ui;
            @(posedge clk);
            #1;
            check_views($sformatf("v%0d", i), vecs[i].exp_d, vecs[i].exp_s);
        end

        // Reset mid-stream with the push strobe held through release
        do_reset();
        ui_in = 8'h28;
        @(posedge clk);
        #1;
        check_views("mr_push1", 8'h08, 8'h01);
        ui_in = 8'h00;
        @(posedge clk);
        #1;
        ui_in = 8'h28;
        @(posedge clk);
        #1;
        check_views("mr_push2", 8'h08, 8'h02);
        rst_n = 1'b0;
        #1;
        ui_in[5] = 1'b1;
        check_views("mr_async", 8'h40, 8'h00);
        @(posedge clk);
        #1;
        check_views("mr_held", 8'h40, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_views("mr_first", 8'h08, 8'h01);
        @(posedge clk);
        #1;
        check_views("mr_hold", 8'h08, 8'h01);
        ui_in = 8'h00;
        @(posedge clk);
        #1;
        check_views("mr_rel", 8'h08, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tt_microtile_sink.md
Name: tt_microtile_sink

Overview:
- Receiving end of the microtile result byte. Captures 5-bit nibble-sum results (0..30) presented on ui_in by an upstream adder tile, and buffers them in a small FIFO.
- Lets the host pop and read results back through uo_out.
- Tracks overflow, underflow and illegal-value conditions.
- Sits as a standalone Tiny Tapeout-style tile, with dedicated in/out pins only.

Parameters:
- DW, 5, result data width. Max legal sum is 30; the value 31 is illegal.
- DEPTH, 4, FIFO entries; must be a power of two.
- CW, 3, occupancy count width, $clog2(DEPTH)+1.

Ports:
- clk  input  1  tile clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- ui_in  input  8  [4:0] result data, [5] push strobe, [6] pop strobe, [7] view select (0=data, 1=status).
- uo_out  output  8  data view: {full, empty, err, head[4:0]}; status view: {ovf, unf, err, 2'b00, count[2:0]}.

Behaviour:
- Reset (async assert, sync release): FIFO pointers=0, count=0, ovf/unf/err=0, push_q/pop_q=0, storage cleared to 0.
- After reset: uo_out=0x40 in data view, 0x00 in status view.
- Strobes are level inputs. The block acts on rising edges only.
- push_evt = ui_in[5] & ~push_q. pop_evt = ui_in[6] & ~pop_q. push_q/pop_q register the raw bits every cycle.
- A held strobe produces exactly one event.
- All decisions at a clock edge use pre-edge state: count, full = (count==DEPTH), empty = (count==0).
- Push accept: push_evt & ~full & (ui_in[4:0]!=31) writes mem[wp] and increments wp (mod DEPTH).
- Push when full, with no pop in the same cycle: data dropped, ovf set.
- Push when full, with a simultaneous pop: both execute and count is unchanged.
- Push with data==31: never stored; err set. Any pop in the same cycle still executes.
- Pop accept: pop_evt & ~empty increments rp (mod DEPTH).
- Pop when empty: ignored, unf set. A same-cycle push still stores, so count goes 0→1.
- count: +1 on push only, −1 on pop only, unchanged on both or neither.
- Latency: a push event sampled at edge k makes its data visible on head after edge k, if the FIFO was empty.
- A pop at edge k exposes the next entry after edge k.
- head = mem[rp]. When empty, head shows 5'b0, not stale data.
- uo_out is a combinational mux of registered state, selected by ui_in[7]. A view switch takes effect the same cycle and never alters state.
- ovf, unf and err are sticky until rst_n is asserted.
- Reset asserted mid-stream: everything returns immediately to reset values. The edge detectors clear, so a strobe held high through reset release causes one event on the first edge after release.
- Pointers wrap silently. Occupancy is derived from count, not from pointer compare.

Decomposition:
- Package tt_microtile_pkg holds:
  - DW, DEPTH, CW
  - ILLEGAL_SUM=5'd31
  - ui_in bit positions (DATA_LSB/MSB, PUSH_BIT, POP_BIT, VIEW_BIT)
  - uo_out field positions for both views
- One sub-module, tt_microtile_edge: registered rising-edge detector with async active-low reset. It is instantiated twice, for push and pop.
- FIFO storage and control stay inline.

Test Plan:
- Reset then idle, toggling view → uo_out=0x40 (data view), 0x00 (status view); no state change.
- Push 5, 17, 30 with one rising edge each, strobe held 3 cycles each → count=3. Head reads 5; pops return 17, 30, then empty=1 with head=0.
- Push 1,2,3,4 (full), then push 9 → full=1, ovf=1, count=4. Pops return 1,2,3,4; the value 9 never appears.
- FIFO full (1,2,3,4): push 7 and pop on the same edge → count stays 4, ovf=0. Popping all returns 2,3,4,7.
- Empty FIFO: pop alone → unf=1. Then push 31 → err=1, count=0. Then push 12 with pop on the same edge → count=1, head=12.
- Push 8, 8, then assert rst_n low mid-cycle with the push strobe held high → outputs return immediately to 0x40/0x00. After release, exactly one event stores 8 (count=1).
